// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source holding FIFOs feeding one registered broadcast port.
// Define CDB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (source 0 highest).
module cdb_arbiter #(
    parameter int BUF_DEPTH = 2,
    parameter int N_SRC     = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  flush,
    input  logic [N_SRC-1:0]      src_valid,
    input  logic [6*N_SRC-1:0]    src_tag,
    input  logic [32*N_SRC-1:0]   src_data,
    output logic [N_SRC-1:0]      src_ready,
    output logic                  cdb_valid,
    output logic [5:0]            cdb_tag,
    output logic [31:0]           cdb_data,
    output logic [1:0]            cdb_src
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OW = PW + 1;

    logic [5:0]    mem_tag_r  [N_SRC][BUF_DEPTH];
    logic [31:0]   mem_data_r [N_SRC][BUF_DEPTH];
    logic [PW-1:0] wr_ptr_r   [N_SRC];
    logic [PW-1:0] rd_ptr_r   [N_SRC];
    logic [OW-1:0] occ_r      [N_SRC];
    logic          ready_en_r;

    logic [N_SRC-1:0] nonempty_s;
    logic [N_SRC-1:0] push_s;
    logic [N_SRC-1:0] pop_s;
    logic [1:0]       grant_s;
    logic [1:0]       cand_s;
    logic             grant_vld_s;

`ifdef CDB_ROUND_ROBIN_EN
    logic [1:0]       rr_ptr_r;
`endif

    // Occupancy-derived status; ready is held low until the first edge out of reset.
    always_comb begin
        nonempty_s = {N_SRC{1'b0}};
        src_ready  = {N_SRC{1'b0}};
        push_s     = {N_SRC{1'b0}};
        for (int i = 0; i < N_SRC; i++) begin
            nonempty_s[i] = (occ_r[i] != OW'(0));
            src_ready[i]  = ready_en_r & (occ_r[i] < OW'(BUF_DEPTH));
            push_s[i]     = src_valid[i] & src_ready[i] & ~flush;
        end
    end

    // Arbitration: scan candidates from lowest priority to highest so the highest wins.
    always_comb begin
        grant_s     = 2'd0;
        grant_vld_s = 1'b0;
        cand_s      = 2'd0;
        pop_s       = {N_SRC{1'b0}};
        for (int k = N_SRC - 1; k >= 0; k--) begin
`ifdef CDB_ROUND_ROBIN_EN
            cand_s = rr_ptr_r + 2'(k);
`else
            cand_s = 2'(k);
`endif
            grant_s     = nonempty_s[cand_s] ? cand_s : grant_s;
            grant_vld_s = grant_vld_s | nonempty_s[cand_s];
        end
        pop_s[grant_s] = grant_vld_s & ~flush;
    end

    // Per-source FIFO storage, pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ready_en_r <= 1'b0;
            for (int i = 0; i < N_SRC; i++) begin
                wr_ptr_r[i] <= {PW{1'b0}};
                rd_ptr_r[i] <= {PW{1'b0}};
                occ_r[i]    <= {OW{1'b0}};
                for (int j = 0; j < BUF_DEPTH; j++) begin
                    mem_tag_r[i][j]  <= 6'd0;
                    mem_data_r[i][j] <= 32'd0;
                end
            end
        end else begin
            ready_en_r <= 1'b1;
            for (int i = 0; i < N_SRC; i++) begin
                if (flush) begin
                    wr_ptr_r[i] <= {PW{1'b0}};
                    rd_ptr_r[i] <= {PW{1'b0}};
                    occ_r[i]    <= {OW{1'b0}};
                end else begin
                    if (push_s[i]) begin
                        mem_tag_r[i][wr_ptr_r[i]]  <= src_tag[6*i +: 6];
                        mem_data_r[i][wr_ptr_r[i]] <= src_data[32*i +: 32];
                        wr_ptr_r[i]                <= wr_ptr_r[i] + PW'(1);
                    end
                    if (pop_s[i]) begin
                        rd_ptr_r[i] <= rd_ptr_r[i] + PW'(1);
                    end
                    case ({push_s[i], pop_s[i]})
                        2'b10:   occ_r[i] <= occ_r[i] + OW'(1);
                        2'b01:   occ_r[i] <= occ_r[i] - OW'(1);
                        default: occ_r[i] <= occ_r[i];
                    endcase
                end
            end
        end
    end

    // Broadcast register: tag/data/src hold when nothing is granted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= 6'd0;
            cdb_data  <= 32'd0;
            cdb_src   <= 2'd0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
        end else if (grant_vld_s) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= mem_tag_r[grant_s][rd_ptr_r[grant_s]];
            cdb_data  <= mem_data_r[grant_s][rd_ptr_r[grant_s]];
            cdb_src   <= grant_s;
        end else begin
            cdb_valid <= 1'b0;
        end
    end

`ifdef CDB_ROUND_ROBIN_EN
    // Round-robin pointer advances past the granted source; idle cycles leave it alone.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr_r <= 2'd0;
        end else if (flush) begin
            rr_ptr_r <= 2'd0;
        end else if (grant_vld_s) begin
            rr_ptr_r <= grant_s + 2'd1;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`endif

endmodule
